// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-align a PC; the low bits are masked rather than sliced off so the whole input is used.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], pc[1:0] & 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO of {pc, instr} entries with push, pop and single-cycle flush.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  // Flush dominates; a push into a full FIFO is only legal alongside a pop.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch with credit-limited requests, redirect flush and response discard.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 4,
  parameter int          CNT_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        instr_misaligned
`endif
);

  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(BUF_DEPTH);

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      resp_pc_reg, resp_pc_next;
  logic [31:0]      last_pc_reg;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] discard_reg, discard_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic [31:0]      redirect_target;
  logic             halted;
  logic             req_fire, rsp_fire;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  fetch_entry_t     push_entry, head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halted_reg, halted_next;
  assign halted           = halted_reg;
  assign instr_misaligned = halted_reg;
  assign redirect_target  = redirect_pc;
`else
  assign halted          = 1'b0;
  assign redirect_target = align_pc(redirect_pc);
`endif

  // Credits cover both buffered entries and responses still owed by memory.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign imem_req_valid = rst_n && !redirect_valid && !halted && (credit_used < CREDIT_MAX);
  assign imem_addr      = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (outstanding_reg != '0);

  assign dec_valid  = !fifo_empty && !redirect_valid;
  assign dec_instr  = dec_valid ? head_entry.instr : NOP_INSTR;
  assign dec_pc     = dec_valid ? head_entry.pc : last_pc_reg;
  assign fifo_pop   = dec_valid && dec_ready;
  assign push_entry = {resp_pc_reg, imem_rsp_data};

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    discard_next     = discard_reg;
    outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    fifo_push        = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    halted_next      = halted_reg;
`endif
    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
      resp_pc_next  = redirect_target;
      // A response landing in the redirect cycle is dropped here, so it is not counted again.
      discard_next  = outstanding_reg - CNT_W'(rsp_fire);
`ifdef FETCH_MISALIGN_CHECK_EN
      halted_next   = |redirect_pc[1:0];
`endif
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + PC_STEP;
      end
      if (rsp_fire) begin
        if (discard_reg != '0) begin
          discard_next = discard_reg - CNT_W'(1);
        end else begin
          fifo_push    = 1'b1;
          resp_pc_next = resp_pc_reg + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      last_pc_reg     <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      last_pc_reg     <= dec_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= halted_next;
    end
  end
`endif

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_reg != '0));

  push_never_overflows: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RSTPC = 32'h0000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        instr_misaligned;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC  (RSTPC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .instr_misaligned (instr_misaligned)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // ---------------- instruction memory: in-order, per-request latency ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend_q[$];
  int    cyc = 0;
  int    lat_cfg = 1;
  bit    lat_rand = 1'b0;
  int    req_count = 0;
  int    last_due = 0;

  initial begin
    logic        fire, rst_s;
    logic [31:0] a;
    int          l, d;
    forever begin
      @(negedge clk);
      fire  = imem_req_valid && imem_req_ready;
      rst_s = rst_n;
      a     = imem_addr;
      l     = lat_rand ? int'($urandom_range(1, 3)) : lat_cfg;
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_s) begin
        pend_q.delete();
        last_due       = 0;
        imem_rsp_valid = 1'b0;
      end else begin
        if (fire) begin
          d = cyc - 1 + l;
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          pend_q.push_back('{a, d});
          req_count++;
        end
        if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = $urandom;
        end
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_fifo[$];
  logic [31:0] m_fetch_pc = RSTPC;
  logic [31:0] m_resp_pc = RSTPC;
  logic [31:0] m_last_pc = '0;
  int          m_out = 0;
  int          m_disc = 0;
  bit          m_halted = 1'b0;
  bit          check_en = 1'b0;

  initial begin
    logic        s_rst, s_rdr, s_req, s_rsp, s_pop, e_req, e_dv;
    logic [31:0] s_rpc, s_data, tgt, e_instr, e_pc;
    forever begin
      @(negedge clk);
      s_rst   = rst_n;
      s_rdr   = redirect_valid;
      s_rpc   = redirect_pc;
      e_req   = s_rst && !s_rdr && !m_halted && (m_fifo.size() + m_out < DEPTH);
      e_dv    = (m_fifo.size() != 0) && !s_rdr;
      e_instr = e_dv ? m_fifo[0].instr : NOP;
      e_pc    = e_dv ? m_fifo[0].pc : m_last_pc;
      if (check_en) begin
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
        chk("imem_addr", imem_addr, m_fetch_pc);
        chk("dec_valid", {31'd0, dec_valid}, {31'd0, e_dv});
        chk("dec_instr", dec_instr, e_instr);
        chk("dec_pc", dec_pc, e_pc);
        if (dec_valid === 1'b1) chk("instr_vs_mem", dec_instr, mem_word(dec_pc));
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misaligned", {31'd0, instr_misaligned}, {31'd0, m_halted});
`endif
      end
      s_req  = e_req && imem_req_ready;
      s_rsp  = imem_rsp_valid && (m_out > 0);
      s_data = imem_rsp_data;
      s_pop  = e_dv && dec_ready;
      @(posedge clk);
      if (!s_rst) begin
        m_fifo.delete();
        m_fetch_pc = RSTPC;
        m_resp_pc  = RSTPC;
        m_last_pc  = '0;
        m_out      = 0;
        m_disc     = 0;
        m_halted   = 1'b0;
      end else begin
        if (e_dv) m_last_pc = m_fifo[0].pc;
        if (s_rdr) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          tgt      = s_rpc;
          m_halted = (s_rpc % 4) != 0;
`else
          tgt      = s_rpc - (s_rpc % 4);
`endif
          m_fifo.delete();
          m_fetch_pc = tgt;
          m_resp_pc  = tgt;
          m_disc     = m_out - int'(s_rsp);
          m_out      = m_out - int'(s_rsp);
        end else begin
          if (s_pop) void'(m_fifo.pop_front());
          if (s_req) begin
            m_fetch_pc = m_fetch_pc + 32'd4;
            m_out++;
          end
          if (s_rsp) begin
            m_out--;
            if (m_disc > 0) begin
              m_disc--;
            end else begin
              m_fifo.push_back('{m_resp_pc, s_data});
              m_resp_pc = m_resp_pc + 32'd4;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (dec_valid !== 1'b1 && k < 20) begin
      tick();
      #2;
      k++;
    end
    n_cmp++;
    if (dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: dec_valid still %b after 20 cycles, expected 1", name, dec_valid);
    end
  endtask

  task automatic restart();
    rst_n = 1'b0;
    repeat (2) tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    // Reset state and streaming from RESET_PC
    rst_n = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1; lat_cfg = 1;
    repeat (3) tick();
    #2;
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_dec_instr", dec_instr, NOP);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_en = 1'b1;
    tick(); rst_n = 1'b1; #2;
    chk("t1_req0", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick(); #2; chk("t1_addr1", imem_addr, 32'h4);
    tick(); #2;
    chk("t1_addr2", imem_addr, 32'h8);
    chk("t1_dv2", {31'd0, dec_valid}, 32'd1);
    chk("t1_pc2", dec_pc, 32'h0);
    chk("t1_instr2", dec_instr, 32'h1357_9BDF);
    tick(); #2; chk("t1_pc3", dec_pc, 32'h4);
    tick(); #2; chk("t1_pc4", dec_pc, 32'h8);

    // Back-pressure fills the buffer, then drains and fetch resumes
    restart(); dec_ready = 1'b0; #2; base = req_count;
    repeat (10) tick();
    #2;
    chk("t2_req_count", req_count - base, 32'd4);
    chk("t2_req_stall", {31'd0, imem_req_valid}, 32'd0);
    chk("t2_head", dec_pc, 32'h0);
    tick(); dec_ready = 1'b1; #2;
    chk("t2_pop0", dec_pc, 32'h0);
    chk("t2_stall0", {31'd0, imem_req_valid}, 32'd0);
    tick(); #2;
    chk("t2_pop1", dec_pc, 32'h4);
    chk("t2_resume_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h10);
    tick(); #2; chk("t2_pop2", dec_pc, 32'h8);
    tick(); #2; chk("t2_pop3", dec_pc, 32'hC);
    tick(); #2; chk("t2_pop4", dec_pc, 32'h10);

    // Redirect with two responses in flight and none arriving that cycle
    restart(); dec_ready = 1'b1; lat_cfg = 1;
    tick();
    tick(); lat_cfg = 3;
    tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; #2;
    chk("t3_rdr_dv", {31'd0, dec_valid}, 32'd0);
    chk("t3_rdr_req", {31'd0, imem_req_valid}, 32'd0);
    tick(); redirect_valid = 1'b0; lat_cfg = 1; #2;
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_req", {31'd0, imem_req_valid}, 32'd1);
    wait_valid("t3_wait");
    chk("t3_first_pc", dec_pc, 32'h100);
    chk("t3_first_instr", dec_instr, mem_word(32'h100));

    // Redirect coinciding with a response arrival and a ready decoder
    lat_cfg = 2;
    repeat (8) tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; #2;
    chk("t4_rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
    chk("t4_rdr_dv", {31'd0, dec_valid}, 32'd0);
    tick(); redirect_valid = 1'b0; #2;
    chk("t4_dv_after", {31'd0, dec_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h200);
    wait_valid("t4_wait");
    chk("t4_first_pc", dec_pc, 32'h200);

    // Reset in the middle of a stream with entries buffered
    lat_cfg = 1; dec_ready = 1'b0;
    repeat (3) tick();
    #2; chk("t5_pre_dv", {31'd0, dec_valid}, 32'd1);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; dec_ready = 1'b1; #2;
    chk("t5_dv", {31'd0, dec_valid}, 32'd0);
    chk("t5_instr", dec_instr, NOP);
    chk("t5_addr", imem_addr, RSTPC);
    chk("t5_pc", dec_pc, 32'd0);

    // Address wrap at the top of the 32-bit space
    repeat (4) tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect_valid = 1'b0; #2;
    wait_valid("wrap_wait");
    chk("wrap_pc0", dec_pc, 32'hFFFF_FFF8);
    tick(); #2; chk("wrap_pc1", dec_pc, 32'hFFFF_FFFC);
    tick(); #2; chk("wrap_pc2", dec_pc, 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetch until an aligned redirect
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick(); redirect_valid = 1'b0; #2;
    chk("t6_flag_set", {31'd0, instr_misaligned}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick(); #2;
    end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick(); redirect_valid = 1'b0; #2;
    chk("t6_flag_clr", {31'd0, instr_misaligned}, 32'd0);
    chk("t6_resume_addr", imem_addr, 32'h200);
    chk("t6_resume_req", {31'd0, imem_req_valid}, 32'd1);
`endif

    // Randomised traffic checked by the model every cycle
    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      dec_ready      = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      rst_n          = ($urandom_range(0, 999) >= 3);
      if ($urandom_range(0, 99) < 3) begin
        redirect_valid = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect_pc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_FFFF)
                                                  : ($urandom & 32'h0000_FFFC);
`else
        redirect_pc = $urandom & 32'h0000_FFFF;
`endif
      end else begin
        redirect_valid = 1'b0;
      end
    end
    tick();
    redirect_valid = 1'b0; rst_n = 1'b1;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
